// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/forwarding controller.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MUL_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int BRANCH_ID = 0;
    localparam int BRANCH_EX = 1;

endpackage

// File: rtl/mips_fwd_sel.sv
// Operand forwarding select for one source register; the MEM stage wins over WB.
module mips_fwd_sel
    import mips_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_mem_rd,
    input  logic              i_mem_rw,
    input  logic [ADDR_W-1:0] i_wb_rd,
    input  logic              i_wb_rw,
    output logic [1:0]        o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // r0 is hardwired to zero, so a write to it never produces a value worth forwarding
    assign w_mem_hit = i_mem_rw && (i_mem_rd != '0) && (i_mem_rd == i_src);
    assign w_wb_hit  = i_wb_rw  && (i_wb_rd  != '0) && (i_wb_rd  == i_src);

    always_comb begin
        o_sel = FWD_REG;
        if (w_mem_hit)
            o_sel = FWD_MEM;
        else if (w_wb_hit)
            o_sel = FWD_WB;
    end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Five-stage MIPS pipeline control: stalls, flushes and forwarding, including
// variable-latency data memory and a multi-cycle multiply/divide unit.
module mips_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int MUL_LAT      = 4,
    parameter int BRANCH_STAGE = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_branch,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mul_start,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              redirect,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              id_ex_we,
    output logic              ex_mem_we,
    output logic              mem_wb_we,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_bubble,
    output logic              pc_redirect_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        fwd_br_a,
    output logic [1:0]        fwd_br_b,
    output logic              mul_busy
);

    localparam int              CNT_W    = $clog2(MUL_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;

    logic w_dstall;
    logic w_lu;
    logic w_bstall;
    logic w_mul_go;

    logic [3:0][ADDR_W-1:0] w_fwd_src;
    logic [3:0][1:0]        w_fwd_sel;

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    assign w_dstall = dmem_req && !dmem_ready;
    assign w_mul_go = ex_mul_start && (MUL_LAT > 1);
    assign w_cnt_dec = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : r_cnt;

    assign w_lu = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                  ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));

    generate
        if (BRANCH_STAGE == BRANCH_ID) begin : g_br_id
            logic w_rs_dep;
            logic w_rt_dep;
            // An ALU result in EX or a load in MEM is not yet visible to the ID comparator
            assign w_rs_dep = (id_rs != '0) &&
                              ((ex_reg_write && (ex_rd == id_rs)) ||
                               (mem_mem_read && mem_reg_write && (mem_rd == id_rs)));
            assign w_rt_dep = (id_rt != '0) &&
                              ((ex_reg_write && (ex_rd == id_rt)) ||
                               (mem_mem_read && mem_reg_write && (mem_rd == id_rt)));
            assign w_bstall = id_is_branch &&
                              ((id_uses_rs && w_rs_dep) || (id_uses_rt && w_rt_dep));
        end else begin : g_br_ex
            assign w_bstall = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Forwarding: 0 = ex_rs, 1 = ex_rt, 2 = id_rs, 3 = id_rt
    // ------------------------------------------------------------------
    assign w_fwd_src = {id_rt, id_rs, ex_rt, ex_rs};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_fwd
            mips_fwd_sel #(
                .ADDR_W (ADDR_W)
            ) u_fwd_sel (
                .i_src    (w_fwd_src[g]),
                .i_mem_rd (mem_rd),
                .i_mem_rw (mem_reg_write),
                .i_wb_rd  (wb_rd),
                .i_wb_rw  (wb_reg_write),
                .o_sel    (w_fwd_sel[g])
            );
        end
    endgenerate

    assign fwd_a    = Rst ? w_fwd_sel[0] : FWD_REG;
    assign fwd_b    = Rst ? w_fwd_sel[1] : FWD_REG;
    assign fwd_br_a = (Rst && (BRANCH_STAGE == BRANCH_ID)) ? w_fwd_sel[2] : FWD_REG;
    assign fwd_br_b = (Rst && (BRANCH_STAGE == BRANCH_ID)) ? w_fwd_sel[3] : FWD_REG;

    assign mul_busy = (r_state == ST_MUL_WAIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and stall priority
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        pc_we          = 1'b1;
        if_id_we       = 1'b1;
        id_ex_we       = 1'b1;
        ex_mem_we      = 1'b1;
        mem_wb_we      = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_mem_bubble  = 1'b0;
        pc_redirect_en = 1'b0;

        if (w_dstall) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
            // The multiplier keeps running under a memory stall; a pending mul start simply waits
            if (r_state == ST_MUL_WAIT)
                w_cnt_nxt = w_cnt_dec;
            else
                w_state_nxt = ST_MEM_WAIT;
        end else if ((r_state == ST_MUL_WAIT) && (r_cnt != '0)) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            ex_mem_bubble = 1'b1;
            w_cnt_nxt     = w_cnt_dec;
        end else if ((r_state != ST_MUL_WAIT) && w_mul_go) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            ex_mem_bubble = 1'b1;
            w_cnt_nxt     = CNT_LOAD;
            w_state_nxt   = ST_MUL_WAIT;
        end else begin
            // Final mul cycle lands here too: result captured and the pipe released together
            w_state_nxt = ST_RUN;
            if ((BRANCH_STAGE == BRANCH_EX) && redirect) begin
                pc_redirect_en = 1'b1;
                if_id_flush    = 1'b1;
                id_ex_bubble   = 1'b1;
            end else if (w_lu || w_bstall) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
            end else if ((BRANCH_STAGE == BRANCH_ID) && redirect) begin
                pc_redirect_en = 1'b1;
                if_id_flush    = 1'b1;
            end
        end

        if (!Rst) begin
            pc_we          = 1'b0;
            if_id_we       = 1'b0;
            id_ex_we       = 1'b0;
            ex_mem_we      = 1'b0;
            mem_wb_we      = 1'b0;
            if_id_flush    = 1'b0;
            id_ex_bubble   = 1'b0;
            ex_mem_bubble  = 1'b0;
            pc_redirect_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Bench for mips_hazard_ctrl: one instance per branch-resolution mode, table vectors
// plus multi-cycle sequences, expectations checked through a scoreboard queue.
module tb_mips_hazard_ctrl;
    import mips_pkg::*;

    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] id_rs;
        logic [AW-1:0] id_rt;
        logic          id_uses_rs;
        logic          id_uses_rt;
        logic          id_is_branch;
        logic [AW-1:0] ex_rs;
        logic [AW-1:0] ex_rt;
        logic [AW-1:0] ex_rd;
        logic          ex_reg_write;
        logic          ex_mem_read;
        logic          ex_mul_start;
        logic [AW-1:0] mem_rd;
        logic          mem_reg_write;
        logic          mem_mem_read;
        logic [AW-1:0] wb_rd;
        logic          wb_reg_write;
        logic          redirect;
        logic          dmem_req;
        logic          dmem_ready;
    } in_t;

    typedef struct packed {
        logic       pc_we;
        logic       if_id_we;
        logic       id_ex_we;
        logic       ex_mem_we;
        logic       mem_wb_we;
        logic       if_id_flush;
        logic       id_ex_bubble;
        logic       ex_mem_bubble;
        logic       pc_redirect_en;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic [1:0] fwd_br_a;
        logic [1:0] fwd_br_b;
        logic       mul_busy;
    } out_t;

    typedef struct {
        in_t  vi;
        out_t vo;
        bit   dut;
    } vec_t;

    logic Clk;
    logic Rst;
    in_t  drv;

    logic [1:0]      pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic [1:0]      if_id_flush, id_ex_bubble, ex_mem_bubble, pc_redirect_en, mul_busy;
    logic [1:0][1:0] fwd_a, fwd_b, fwd_br_a, fwd_br_b;

    out_t  exp_q[$];
    bit    dut_q[$];
    string name_q[$];
    int    n_run  = 0;
    int    n_fail = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // instance 0: branches resolved in ID, instance 1: resolved in EX
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mips_hazard_ctrl #(
            .ADDR_W       (AW),
            .MUL_LAT      (4),
            .BRANCH_STAGE (g)
        ) u_dut (
            .Clk            (Clk),
            .Rst            (Rst),
            .id_rs          (drv.id_rs),
            .id_rt          (drv.id_rt),
            .id_uses_rs     (drv.id_uses_rs),
            .id_uses_rt     (drv.id_uses_rt),
            .id_is_branch   (drv.id_is_branch),
            .ex_rs          (drv.ex_rs),
            .ex_rt          (drv.ex_rt),
            .ex_rd          (drv.ex_rd),
            .ex_reg_write   (drv.ex_reg_write),
            .ex_mem_read    (drv.ex_mem_read),
            .ex_mul_start   (drv.ex_mul_start),
            .mem_rd         (drv.mem_rd),
            .mem_reg_write  (drv.mem_reg_write),
            .mem_mem_read   (drv.mem_mem_read),
            .wb_rd          (drv.wb_rd),
            .wb_reg_write   (drv.wb_reg_write),
            .redirect       (drv.redirect),
            .dmem_req       (drv.dmem_req),
            .dmem_ready     (drv.dmem_ready),
            .pc_we          (pc_we[g]),
            .if_id_we       (if_id_we[g]),
            .id_ex_we       (id_ex_we[g]),
            .ex_mem_we      (ex_mem_we[g]),
            .mem_wb_we      (mem_wb_we[g]),
            .if_id_flush    (if_id_flush[g]),
            .id_ex_bubble   (id_ex_bubble[g]),
            .ex_mem_bubble  (ex_mem_bubble[g]),
            .pc_redirect_en (pc_redirect_en[g]),
            .fwd_a          (fwd_a[g]),
            .fwd_b          (fwd_b[g]),
            .fwd_br_a       (fwd_br_a[g]),
            .fwd_br_b       (fwd_br_b[g]),
            .mul_busy       (mul_busy[g])
        );
    end

    function automatic out_t cur(input int g);
        return {pc_we[g], if_id_we[g], id_ex_we[g], ex_mem_we[g], mem_wb_we[g],
                if_id_flush[g], id_ex_bubble[g], ex_mem_bubble[g], pc_redirect_en[g],
                fwd_a[g], fwd_b[g], fwd_br_a[g], fwd_br_b[g], mul_busy[g]};
    endfunction

    function automatic in_t nop();
        in_t v;
        v = '0;
        v.dmem_ready = 1'b1;
        return v;
    endfunction

    function automatic out_t run(input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00,
                                 input logic [1:0] fba = 2'b00, input logic [1:0] fbb = 2'b00);
        out_t o;
        o = '0;
        o.pc_we     = 1'b1;
        o.if_id_we  = 1'b1;
        o.id_ex_we  = 1'b1;
        o.ex_mem_we = 1'b1;
        o.mem_wb_we = 1'b1;
        o.fwd_a     = fa;
        o.fwd_b     = fb;
        o.fwd_br_a  = fba;
        o.fwd_br_b  = fbb;
        return o;
    endfunction

    function automatic out_t stall_o(input logic [1:0] fba = 2'b00);
        out_t o;
        o = run(2'b00, 2'b00, fba);
        o.pc_we        = 1'b0;
        o.if_id_we     = 1'b0;
        o.id_ex_bubble = 1'b1;
        return o;
    endfunction

    function automatic out_t frz(input logic busy);
        out_t o;
        o = '0;
        o.mem_wb_we     = 1'b1;
        o.ex_mem_bubble = 1'b1;
        o.mul_busy      = busy;
        return o;
    endfunction

    task automatic check_one();
        out_t  e;
        out_t  a;
        bit    d;
        string nm;
        e  = exp_q.pop_front();
        d  = dut_q.pop_front();
        nm = name_q.pop_front();
        a  = cur(int'(d));
        n_run++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %05h expected %05h", nm, d, a, e);
        end
    endtask

    task automatic step(input in_t v, input out_t e, input bit d, input string nm);
        drv = v;
        exp_q.push_back(e);
        dut_q.push_back(d);
        name_q.push_back(nm);
        @(negedge Clk);
        check_one();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        in_t  v;
        in_t  vd;
        out_t e;
        vec_t tq[$];

        Rst = 1'b0;
        drv = nop();

        // ---------------- table ----------------
        v = nop();
        tq.push_back('{v, run(), 1'b0});
        v = nop(); v.ex_rs = 5; v.mem_rd = 5; v.wb_rd = 5; v.mem_reg_write = 1; v.wb_reg_write = 1;
        tq.push_back('{v, run(2'b10), 1'b0});
        v = nop(); v.mem_reg_write = 1; v.wb_reg_write = 1;
        tq.push_back('{v, run(), 1'b0});
        v = nop(); v.ex_rt = 7; v.wb_rd = 7; v.wb_reg_write = 1;
        tq.push_back('{v, run(2'b00, 2'b01), 1'b0});
        v.mem_rd = 7;
        tq.push_back('{v, run(2'b00, 2'b01), 1'b0});
        v = nop(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 9; v.id_rt = 9; v.id_uses_rt = 1;
        tq.push_back('{v, stall_o(), 1'b0});
        v.id_uses_rt = 0;
        tq.push_back('{v, run(), 1'b0});
        v = nop(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.id_uses_rs = 1;
        tq.push_back('{v, run(), 1'b0});
        v = nop(); v.redirect = 1;
        e = run(); e.pc_redirect_en = 1; e.if_id_flush = 1;
        tq.push_back('{v, e, 1'b0});
        v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 6; v.id_rs = 6; v.id_uses_rs = 1;
        tq.push_back('{v, stall_o(), 1'b0});
        e = run(); e.pc_redirect_en = 1; e.if_id_flush = 1; e.id_ex_bubble = 1;
        tq.push_back('{v, e, 1'b1});
        v = nop(); v.id_is_branch = 1; v.id_rs = 4; v.id_uses_rs = 1; v.ex_reg_write = 1; v.ex_rd = 4;
        tq.push_back('{v, stall_o(), 1'b0});
        tq.push_back('{v, run(), 1'b1});
        v = nop(); v.id_is_branch = 1; v.id_rs = 4; v.id_uses_rs = 1; v.mem_rd = 4; v.mem_reg_write = 1;
        tq.push_back('{v, run(2'b00, 2'b00, 2'b10), 1'b0});
        tq.push_back('{v, run(), 1'b1});
        v = nop(); v.dmem_req = 1; v.dmem_ready = 0; v.redirect = 1;
        tq.push_back('{v, '0, 1'b0});
        v = nop(); v.dmem_req = 1;
        tq.push_back('{v, run(), 1'b0});

        // ---------------- reset state ----------------
        v = nop(); v.ex_rs = 5; v.wb_rd = 5; v.wb_reg_write = 1;
        step(v, '0, 1'b0, "reset_hold");
        Rst = 1'b1;

        for (int i = 0; i < tq.size(); i++)
            step(tq[i].vi, tq[i].vo, tq[i].dut, $sformatf("vec%0d", i));

        // ---------------- load-use then WB forward ----------------
        v = nop(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 8; v.id_rs = 8; v.id_uses_rs = 1;
        step(v, stall_o(), 1'b0, "lu_bubble");
        v = nop(); v.ex_rs = 8; v.wb_rd = 8; v.wb_reg_write = 1;
        step(v, run(2'b01), 1'b0, "lu_fwd_wb");

        // ---------------- ID branch on load: two bubbles ----------------
        v = nop(); v.id_is_branch = 1; v.id_rs = 3; v.id_uses_rs = 1; v.redirect = 1;
        v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 3;
        step(v, stall_o(), 1'b0, "brld_c0");
        v.ex_mem_read = 0; v.ex_reg_write = 0; v.ex_rd = 0;
        v.mem_rd = 3; v.mem_mem_read = 1; v.mem_reg_write = 1;
        step(v, stall_o(2'b10), 1'b0, "brld_c1");
        v.mem_rd = 0; v.mem_mem_read = 0; v.mem_reg_write = 0;
        v.wb_rd = 3; v.wb_reg_write = 1;
        e = run(2'b00, 2'b00, 2'b01); e.pc_redirect_en = 1; e.if_id_flush = 1;
        step(v, e, 1'b0, "brld_c2");

        // ---------------- multiply, MUL_LAT=4 ----------------
        v = nop(); v.ex_mul_start = 1;
        step(v, frz(1'b0), 1'b0, "mul_c0");
        step(v, frz(1'b1), 1'b0, "mul_c1");
        step(v, frz(1'b1), 1'b0, "mul_c2");
        e = run(); e.mul_busy = 1;
        step(v, e, 1'b0, "mul_capture");
        step(nop(), run(), 1'b0, "mul_done");

        // ---------------- dstall inside MUL_WAIT ----------------
        step(v, frz(1'b0), 1'b0, "muld_start");
        vd = v; vd.dmem_req = 1; vd.dmem_ready = 0;
        e = '0; e.mul_busy = 1;
        for (int i = 0; i < 5; i++)
            step(vd, e, 1'b0, $sformatf("muld_stall%0d", i));
        vd.dmem_ready = 1;
        e = run(); e.mul_busy = 1;
        step(vd, e, 1'b0, "muld_release");
        step(nop(), run(), 1'b0, "muld_run");

        // ---------------- reset pulse mid MUL_WAIT ----------------
        step(v, frz(1'b0), 1'b0, "mulr_start");
        step(v, frz(1'b1), 1'b0, "mulr_wait");
        Rst = 1'b0;
        vd = v; vd.ex_rs = 5; vd.wb_rd = 5; vd.wb_reg_write = 1;
        step(vd, '0, 1'b0, "mulr_in_reset");
        step(vd, '0, 1'b1, "mulr_in_reset_ex");
        Rst = 1'b1;
        step(nop(), run(), 1'b0, "mulr_after");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_hazard_ctrl.md
# mips_hazard_ctrl

Parametrised pipeline-control block for the five-stage MIPS core that merges hazard detection and forwarding and adds stalls for variable-latency data memory and a multi-cycle multiply/divide unit. It sits beside the pipelined datapath. From the register indices and control bits of each stage it produces:

- per-register write enables,
- flush/bubble controls,
- forwarding selects for EX operands and for the ID-stage branch comparator.

Branch resolution stage is a mode parameter.

## Interface

- `ADDR_W`, 5: register-index width.
- `MUL_LAT`, 4: mul/div latency in cycles, ≥1.
- `BRANCH_STAGE`, 0: 0 = branches/jr resolved in ID; 1 = resolved in EX.

Ports:

- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  reset, asynchronous, active-low.
- `id_rs`, `id_rt`  in  ADDR_W  source registers of the ID instruction.
- `id_uses_rs`, `id_uses_rt`  in  1  ID instruction reads that source.
- `id_is_branch`  in  1  ID instruction is beq/bne/jr.
- `ex_rs`, `ex_rt`, `ex_rd`  in  ADDR_W  EX-stage sources and destination.
- `ex_reg_write`, `ex_mem_read`, `ex_mul_start`  in  1  EX-stage control.
- `mem_rd`  in  ADDR_W  MEM-stage destination.
- `mem_reg_write`, `mem_mem_read`  in  1  MEM-stage control.
- `wb_rd`  in  ADDR_W  WB-stage destination.
- `wb_reg_write`  in  1  WB-stage control.
- `redirect`  in  1  taken branch/jump computed in the `BRANCH_STAGE` stage.
- `dmem_req`, `dmem_ready`  in  1  MEM-stage memory access / completion.
- `pc_we`, `if_id_we`, `id_ex_we`, `ex_mem_we`, `mem_wb_we`  out  1  pipeline-register enables.
- `if_id_flush`, `id_ex_bubble`, `ex_mem_bubble`  out  1  load NOP into that register.
- `pc_redirect_en`  out  1  select redirect target into PC.
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 register file, 01 WB, 10 MEM.
- `fwd_br_a`, `fwd_br_b`  out  2  ID comparator select, same encoding.
- `mul_busy`  out  1  FSM in MUL_WAIT.

## Operation

FSM states: RUN, MEM_WAIT, MUL_WAIT. A down-counter `cnt` is $clog2(MUL_LAT)+1 bits wide.

**Signal definitions**

- `dstall` = `dmem_req & ~dmem_ready`.
- `lu` (load-use) = `ex_mem_read & ex_reg_write & ex_rd≠0` & ((`id_uses_rs` & `ex_rd==id_rs`) | (`id_uses_rt` & `ex_rd==id_rt`)).
- `bstall`: only when `BRANCH_STAGE==0` and `id_is_branch`. Asserted on an operand match with either:
  - an EX `reg_write` (ALU result not yet available), or
  - a MEM load (`mem_mem_read & mem_reg_write`).

**Stall priority: dstall > MUL_WAIT > redirect(EX mode) > lu|bstall > redirect(ID mode)**

- **dstall (any state):** all five enables 0; no flush or bubble; `pc_redirect_en` 0.
- **MUL_WAIT (without dstall):**
  - `pc_we`/`if_id_we`/`id_ex_we` = 0.
  - `ex_mem_bubble` = 1 while `cnt≠0`; `mem_wb_we` = 1.
  - On the cycle `cnt==0`: `ex_mem_we` = 1, no bubble (result captured), then go to RUN.
- **RUN, `ex_mul_start` with `MUL_LAT>1`:** same freeze as MUL_WAIT; load `cnt=MUL_LAT-2`; go to MUL_WAIT. With `MUL_LAT==1` there is no stall.
- **redirect, `BRANCH_STAGE==1`:** `pc_redirect_en`, `pc_we`, `if_id_flush`, `id_ex_bubble` = 1. This overrides `lu`, because the younger instruction is squashed.
- **lu | bstall:** `pc_we`=0, `if_id_we`=0, `id_ex_bubble`=1.
- **redirect, `BRANCH_STAGE==0`:** honoured only without bstall/lu. Drives `pc_redirect_en`=1, `if_id_flush`=1.
- **Otherwise:** all enables 1, no flush or bubble.

**Forwarding (combinational, all states)**

- MEM source: `mem_reg_write & mem_rd≠0 & mem_rd==src`, producing 10.
- WB source: `wb_reg_write & wb_rd≠0 & wb_rd==src`, producing 01.
- MEM has priority over WB.
- EX selects use `ex_rs`/`ex_rt`.
- Branch selects use `id_rs`/`id_rt`. When `BRANCH_STAGE==1` the branch selects are tied to 00.

## Timing

- Outputs are combinational from inputs and state. The state update is registered.
- Reset:
  - State RUN, `cnt`=0, `mul_busy`=0.
  - While `Rst` is low, all enables, flushes and bubbles are 0 and `fwd_*` are 00.
  - Reset asserted mid-MUL_WAIT aborts the operation. Release returns to RUN.
- Load-use costs exactly 1 bubble. An ID-branch dependent on an ALU result costs 1 bubble; one dependent on a load costs 2.
- A mul stalls younger instructions for `MUL_LAT-1` cycles.
- dstall arriving in MUL_WAIT: `cnt` keeps decrementing, but `ex_mem_we`/`mem_wb_we` stay 0. Exit MUL_WAIT only when `cnt==0` and there is no dstall.
- dstall in RUN with `ex_mul_start`: the mul start is deferred. EX is frozen, so the input remains held and `cnt` loads on the first non-dstall cycle.
- `ex_mul_start` and an EX redirect are mutually exclusive by the decoder.

## Structure

- `mips_pkg`:
  - state enum,
  - forwarding-select localparams (`FWD_REG`, `FWD_WB`, `FWD_MEM`),
  - `BRANCH_ID`/`BRANCH_EX` constants.
- One sub-module, `mips_fwd_sel`, instantiated 4×. It is purely combinational: (src, `mem_rd`, `mem_rw`, `wb_rd`, `wb_rw`) → 2-bit select.
- FSM, counter and stall priority live in the top.

## Test plan

- **Load-use:** `ex_mem_read=1`, `ex_rd=8`, `id_rs=8`, `id_uses_rs=1` → one cycle with `pc_we=0`, `if_id_we=0`, `id_ex_bubble=1`. Next cycle: `fwd_a=01` with `wb_rd=8`.
- **Forward priority:** `mem_rd=wb_rd=ex_rs=5`, both `reg_write=1` → `fwd_a=10`. With register 0 in all three positions → `fwd_a=00`.
- **Multiply, `MUL_LAT=4`:** `ex_mul_start` pulse → `mul_busy` high 3 cycles; `pc_we=0` for 3 cycles; `ex_mem_we=1` without bubble on the 3rd.
- **`BRANCH_STAGE=0`, beq on a load result:** `id_rs=3` with a load to r3 in EX → 2 bubbles, then `fwd_br_a=01`. `pc_redirect_en` must stay 0 until the stall clears.
- **`BRANCH_STAGE=1`, redirect concurrent with `lu`:** → `pc_redirect_en=1`, `if_id_flush=1`, `id_ex_bubble=1`, `pc_we=1`.
- **dstall inside MUL_WAIT:** `dmem_ready=0` for 5 cycles → all enables 0 and `cnt` reaches 0. RUN is entered only after `dmem_ready=1`. Pulsing `Rst` low mid-wait → RUN, `mul_busy=0`.
